// File: rtl/mc_ctl_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states and
// instruction field positions.
package mc_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH0,
        ST_FETCH1,
        ST_DEC0,
        ST_DEC1,
        ST_EXEC0,
        ST_EXEC1,
        ST_HALT
    } state_e;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_LSF = 5'd2;
    localparam logic [4:0] OP_RSF = 5'd3;
    localparam logic [4:0] OP_AND = 5'd4;
    localparam logic [4:0] OP_OR  = 5'd5;
    localparam logic [4:0] OP_XOR = 5'd6;
    localparam logic [4:0] OP_LHI = 5'd7;
    localparam logic [4:0] OP_LD  = 5'd8;
    localparam logic [4:0] OP_ST  = 5'd9;
    localparam logic [4:0] OP_JLT = 5'd16;
    localparam logic [4:0] OP_JLE = 5'd17;
    localparam logic [4:0] OP_JEQ = 5'd18;
    localparam logic [4:0] OP_JNE = 5'd19;
    localparam logic [4:0] OP_JIN = 5'd20;
    localparam logic [4:0] OP_HLT = 5'd24;

    localparam int OPC_LSB  = 25;
    localparam int DST_LSB  = 22;
    localparam int SRC0_LSB = 19;
    localparam int SRC1_LSB = 16;
    localparam int IMM_W    = 16;
    localparam int INST_W   = 30;

    // Ops whose result is written back to dst from the ALU output.
    function automatic logic is_alu_op(input logic [4:0] op);
        return op <= OP_LHI;
    endfunction

    function automatic logic is_cond_jump(input logic [4:0] op);
        return (op == OP_JLT) || (op == OP_JLE) || (op == OP_JEQ) || (op == OP_JNE);
    endfunction

endpackage

// File: rtl/mc_ctl_regfile.sv
// Register file r2..r7 with two combinational read ports and one synchronous
// write port; r0 reads zero, r1 reads the current immediate.
module mc_ctl_regfile
    import mc_ctl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    rd0_addr_i,
    output logic [DW-1:0] rd0_data_o,
    input  logic [2:0]    rd1_addr_i,
    output logic [DW-1:0] rd1_data_o,
    input  logic [DW-1:0] imm_i,
    input  logic          we_i,
    input  logic [2:0]    wr_addr_i,
    input  logic [DW-1:0] wr_data_i
);

    logic [DW-1:0] regs_q [2:7];

    // NOTE: the register file is small and software relies on r2..r7 reading zero after reset,
    // so every entry is cleared rather than left uninitialised like a RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 2; i < 8; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            for (int i = 2; i < 8; i++) begin
                if (wr_addr_i == 3'(i)) regs_q[i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        rd0_data_o = '0;
        rd1_data_o = '0;
        if (rd0_addr_i == 3'd1) rd0_data_o = imm_i;
        if (rd1_addr_i == 3'd1) rd1_data_o = imm_i;
        for (int i = 2; i < 8; i++) begin
            if (rd0_addr_i == 3'(i)) rd0_data_o = regs_q[i];
            if (rd1_addr_i == 3'(i)) rd1_data_o = regs_q[i];
        end
    end

endmodule

// File: rtl/mc_ctl.sv
// Multicycle fetch/decode/execute controller for the SP core, driving a
// single-port SRAM with configurable read latency and an external ALU.
module mc_ctl
    import mc_ctl_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    output logic          mem_en,
    output logic          mem_we,
    input  logic [DW-1:0] mem_do,
    output logic [4:0]    opcode,
    output logic [DW-1:0] alu0,
    output logic [DW-1:0] alu1,
    input  logic [DW-1:0] alu_out,
    output logic          busy,
    output logic          halted,
    output logic [31:0]   retired_cnt
);

    localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e              state_q, state_d;
    logic [AW-1:0]       pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [4:0]          opcode_q, opcode_d;
    logic [2:0]          dst_q, dst_d, src0_q, src0_d, src1_q, src1_d;
    logic [DW-1:0]       imm_q, imm_d;
    logic [DW-1:0]       alu0_q, alu0_d, alu1_q, alu1_d, aluout_q, aluout_d;
    logic [31:0]         retired_q, retired_d;
    logic [WW-1:0]       wait_q, wait_d;

    logic          wait_done, wait_count;
    logic [AW-1:0] pc_inc;
    logic [2:0]    rd0_addr;
    logic [DW-1:0] rd0_data, rd1_data;
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    mc_ctl_regfile #(.DW(DW)) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .rd0_addr_i (rd0_addr),
        .rd0_data_o (rd0_data),
        .rd1_addr_i (src1_q),
        .rd1_data_o (rd1_data),
        .imm_i      (imm_q),
        .we_i       (rf_we),
        .wr_addr_i  (rf_waddr),
        .wr_data_i  (rf_wdata)
    );

    assign wait_done = (wait_q == WW'(MEM_LAT - 1));
    assign pc_inc    = pc_q + AW'(1);
    assign rd0_addr  = (opcode_q == OP_LHI) ? dst_q : src0_q;

    // NOTE: every next-state signal gets its hold value first, so no path through this block
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        opcode_d  = opcode_q;
        dst_d     = dst_q;
        src0_d    = src0_q;
        src1_d    = src1_q;
        imm_d     = imm_q;
        alu0_d    = alu0_q;
        alu1_d    = alu1_q;
        aluout_d  = aluout_q;
        retired_d = retired_q;
        rf_we     = 1'b0;
        rf_waddr  = dst_q;
        rf_wdata  = aluout_q;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH0;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: begin
                if (wait_done) begin
                    inst_d  = mem_do[INST_W-1:0];
                    state_d = ST_DEC0;
                end
            end
            ST_DEC0: begin
                opcode_d = inst_q[OPC_LSB +: 5];
                dst_d    = inst_q[DST_LSB +: 3];
                src0_d   = inst_q[SRC0_LSB +: 3];
                src1_d   = inst_q[SRC1_LSB +: 3];
                imm_d    = {{(DW-IMM_W){inst_q[IMM_W-1]}}, inst_q[IMM_W-1:0]};
                state_d  = ST_DEC1;
            end
            ST_DEC1: begin
                alu0_d  = rd0_data;
                alu1_d  = (opcode_q == OP_LHI) ? imm_q : rd1_data;
                state_d = ST_EXEC0;
            end
            ST_EXEC0: begin
                aluout_d = alu_out;
                state_d  = ST_EXEC1;
            end
            ST_EXEC1: begin
                if (opcode_q == OP_LD) begin
                    if (wait_done) begin
                        rf_we     = 1'b1;
                        rf_wdata  = mem_do;
                        pc_d      = pc_inc;
                        retired_d = retired_q + 32'd1;
                        state_d   = ST_FETCH0;
                    end
                end else begin
                    pc_d      = pc_inc;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH0;
                    if (is_alu_op(opcode_q)) begin
                        rf_we = 1'b1;
                    end else if (is_cond_jump(opcode_q)) begin
                        if (aluout_q != '0) begin
                            rf_we    = 1'b1;
                            rf_waddr = 3'd7;
                            rf_wdata = DW'(pc_q);
                            pc_d     = imm_q[AW-1:0];
                        end
                    end else if (opcode_q == OP_JIN) begin
                        rf_we    = 1'b1;
                        rf_waddr = 3'd7;
                        rf_wdata = DW'(pc_q);
                        pc_d     = alu0_q[AW-1:0];
                    end else if (opcode_q == OP_HLT) begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The SRAM latency counter restarts on every state change.
    assign wait_count = (state_q == ST_FETCH1) || ((state_q == ST_EXEC1) && (opcode_q == OP_LD));
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) wait_d = '0;
        else if (wait_count)    wait_d = wait_q + WW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            opcode_q  <= '0;
            dst_q     <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            imm_q     <= '0;
            alu0_q    <= '0;
            alu1_q    <= '0;
            aluout_q  <= '0;
            retired_q <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            opcode_q  <= opcode_d;
            dst_q     <= dst_d;
            src0_q    <= src0_d;
            src1_q    <= src1_d;
            imm_q     <= imm_d;
            alu0_q    <= alu0_d;
            alu1_q    <= alu1_d;
            aluout_q  <= aluout_d;
            retired_q <= retired_d;
            wait_q    <= wait_d;
        end
    end

    // The write strobe is gated by reset so an aborted store never reaches the SRAM.
    assign mem_we      = (state_q == ST_EXEC1) && (opcode_q == OP_ST) && !reset;
    assign mem_addr    = ((state_q == ST_FETCH0) || (state_q == ST_FETCH1)) ? pc_q : alu1_q[AW-1:0];
    assign mem_di      = alu0_q;
    assign mem_en      = 1'b1;
    assign opcode      = opcode_q;
    assign alu0        = alu0_q;
    assign alu1        = alu1_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted      = (state_q == ST_HALT);
    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_mc_ctl.sv
// Bench for mc_ctl: three instances (MEM_LAT=1/AW=16, MEM_LAT=3/AW=16, MEM_LAT=1/AW=4)
// each with its own SRAM and ALU model; SRAM stores are scored against a queue.
module tb_mc_ctl;
    import mc_ctl_pkg::*;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NCFG-1:0] reset_v, start_v;
    logic [NCFG-1:0] we_o, en_o, busy_o, halted_o;
    logic [15:0]     addr_o [NCFG];
    logic [31:0]     di_o   [NCFG];
    logic [31:0]     ret_o  [NCFG];

    logic        ld_we;
    logic [1:0]  ld_cfg;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          cfg;
        logic [15:0] addr;
        logic [31:0] data;
    } st_t;
    st_t exp_q[$];

    logic [15:0] addr_log [64];

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int LAT = (g == 1) ? 3 : 1;
        localparam int AWG = (g == 2) ? 4 : 16;

        logic [AWG-1:0] mem_addr;
        logic [31:0]    mem_di, mem_do, alu0, alu1, alu_out, retired_cnt;
        logic [4:0]     opcode;
        logic           mem_en, mem_we, busy, halted;
        logic [31:0]    mem  [256];
        logic [31:0]    pipe [LAT];

        mc_ctl #(.DW(32), .AW(AWG), .MEM_LAT(LAT)) dut (
            .clk         (clk),
            .reset       (reset_v[g]),
            .start       (start_v[g]),
            .mem_addr    (mem_addr),
            .mem_di      (mem_di),
            .mem_en      (mem_en),
            .mem_we      (mem_we),
            .mem_do      (mem_do),
            .opcode      (opcode),
            .alu0        (alu0),
            .alu1        (alu1),
            .alu_out     (alu_out),
            .busy        (busy),
            .halted      (halted),
            .retired_cnt (retired_cnt)
        );

        always_comb begin
            alu_out = '0;
            case (opcode)
                OP_ADD:  alu_out = alu0 + alu1;
                OP_SUB:  alu_out = alu0 - alu1;
                OP_LSF:  alu_out = alu0 << alu1[4:0];
                OP_RSF:  alu_out = alu0 >> alu1[4:0];
                OP_AND:  alu_out = alu0 & alu1;
                OP_OR:   alu_out = alu0 | alu1;
                OP_XOR:  alu_out = alu0 ^ alu1;
                OP_LHI:  alu_out = {alu1[15:0], alu0[15:0]};
                OP_JLT:  alu_out = {31'b0, $signed(alu0) <  $signed(alu1)};
                OP_JLE:  alu_out = {31'b0, $signed(alu0) <= $signed(alu1)};
                OP_JEQ:  alu_out = {31'b0, alu0 == alu1};
                OP_JNE:  alu_out = {31'b0, alu0 != alu1};
                default: alu_out = '0;
            endcase
        end

        always @(posedge clk) begin
            if (ld_we && ld_cfg == 2'(g)) mem[ld_addr] <= ld_data;
            else if (mem_we)              mem[8'(mem_addr)] <= mem_di;
            pipe[0] <= mem[8'(mem_addr)];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_do = pipe[LAT-1];

        assign we_o[g]     = mem_we;
        assign en_o[g]     = mem_en;
        assign busy_o[g]   = busy;
        assign halted_o[g] = halted;
        assign addr_o[g]   = 16'(mem_addr);
        assign di_o[g]     = mem_di;
        assign ret_o[g]    = retired_cnt;
    end

    function automatic logic [31:0] enc(input logic [4:0] op, input int d, input int s0,
                                        input int s1, input int imm);
        return {2'b00, op, 3'(d), 3'(s0), 3'(s1), 16'(imm)};
    endfunction

    task automatic load(input int k, input int a, input logic [31:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_cfg  = 2'(k);
        ld_addr = 8'(a);
        ld_data = d;
        @(posedge clk);
        #1 ld_we = 1'b0;
    endtask

    task automatic clear_mem(input int k);
        for (int i = 0; i < 256; i++) load(k, i, 32'h0);
    endtask

    // Starts instance k, scores stores until it halts; poke_iter re-asserts start mid-run.
    task automatic run(input int k, input int budget, input int poke_iter, output int halt_iter);
        st_t e;
        halt_iter = -1;
        @(negedge clk) start_v[k] = 1'b1;
        @(negedge clk) start_v[k] = 1'b0;
        for (int it = 0; it <= budget; it++) begin
            if (it < 64) addr_log[it] = addr_o[k];
            start_v[k] = (it == poke_iter);
            if (we_o[k]) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL store cfg%0d: unexpected write addr=%0d data=%h", k, addr_o[k], di_o[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cfg != k || addr_o[k] !== e.addr || di_o[k] !== e.data) begin
                        bad++;
                        $display("FAIL store cfg%0d: got addr=%0d data=%h, want cfg%0d addr=%0d data=%h",
                                 k, addr_o[k], di_o[k], e.cfg, e.addr, e.data);
                    end
                end
            end
            if (halted_o[k]) begin
                halt_iter = it;
                break;
            end
            @(negedge clk);
        end
        start_v[k] = 1'b0;
        total++;
        if (halt_iter < 0) begin
            bad++;
            $display("FAIL halt cfg%0d: no halt within %0d cycles", k, budget);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL store cfg%0d: %0d expected writes never seen", k, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int k = 0; k < NCFG; k++) clear_mem(k);
        @(negedge clk) reset_v = '0;
        @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            total += 5;
            if (busy_o[k] !== 1'b0 || halted_o[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_status cfg%0d: busy=%b halted=%b, want 0 0", k, busy_o[k], halted_o[k]);
            end
            if (we_o[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_we cfg%0d: got %b want 0", k, we_o[k]);
            end
            if (addr_o[k] !== 16'd0) begin
                bad++;
                $display("FAIL reset_addr cfg%0d: got %0d want 0", k, addr_o[k]);
            end
            if (ret_o[k] !== 32'd0) begin
                bad++;
                $display("FAIL reset_retired cfg%0d: got %0d want 0", k, ret_o[k]);
            end
            if (en_o[k] !== 1'b1) begin
                bad++;
                $display("FAIL reset_en cfg%0d: got %b want 1", k, en_o[k]);
            end
        end
    endtask

    task automatic test_basic();
        int h;
        clear_mem(0);
        load(0, 0, enc(OP_ADD, 2, 1, 0, 5));
        load(0, 1, enc(OP_HLT, 0, 0, 0, 0));
        run(0, 100, 3, h);
        total += 3;
        if (h !== 12) begin
            bad++;
            $display("FAIL basic_halt_cycle: got %0d want 12", h);
        end
        if (ret_o[0] !== 32'd2) begin
            bad++;
            $display("FAIL basic_retired: got %0d want 2", ret_o[0]);
        end
        if (busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_in_halt: got %b want 0", busy_o[0]);
        end
        // Restart from HALT keeps r2, which is stored out to observe it.
        load(0, 0, enc(OP_ST, 0, 2, 1, 200));
        exp_q.push_back('{cfg: 0, addr: 16'd200, data: 32'd5});
        run(0, 100, -1, h);
        total++;
        if (ret_o[0] !== 32'd2) begin
            bad++;
            $display("FAIL basic_restart_retired: got %0d want 2", ret_o[0]);
        end
    endtask

    task automatic test_latency();
        int h;
        load(1, 0, enc(OP_ADD, 2, 1, 0, 5));
        load(1, 1, enc(OP_HLT, 0, 0, 0, 0));
        run(1, 100, -1, h);
        total++;
        if (h !== 16) begin
            bad++;
            $display("FAIL lat3_halt_cycle: got %0d want 16", h);
        end
        for (int i = 0; i < 4; i++) begin
            total += 2;
            if (addr_log[i] !== 16'd0) begin
                bad++;
                $display("FAIL lat3_fetch_addr0 cyc%0d: got %0d want 0", i, addr_log[i]);
            end
            if (addr_log[i+8] !== 16'd1) begin
                bad++;
                $display("FAIL lat3_fetch_addr1 cyc%0d: got %0d want 1", i + 8, addr_log[i+8]);
            end
        end
    endtask

    task automatic test_ld_st(input int k, input int exp_h);
        int h;
        clear_mem(k);
        load(k, 0, enc(OP_ADD, 2, 1, 0, 16'h1234));
        load(k, 1, enc(OP_ST,  0, 2, 1, 100));
        load(k, 2, enc(OP_LD,  3, 0, 1, 100));
        load(k, 3, enc(OP_ST,  0, 3, 1, 101));
        load(k, 4, enc(OP_HLT, 0, 0, 0, 0));
        exp_q.push_back('{cfg: k, addr: 16'd100, data: 32'h1234});
        exp_q.push_back('{cfg: k, addr: 16'd101, data: 32'h1234});
        run(k, 200, -1, h);
        total += 2;
        if (h !== exp_h) begin
            bad++;
            $display("FAIL ldst_halt_cycle cfg%0d: got %0d want %0d", k, h, exp_h);
        end
        if (ret_o[k] !== 32'd5) begin
            bad++;
            $display("FAIL ldst_retired cfg%0d: got %0d want 5", k, ret_o[k]);
        end
    endtask

    task automatic test_jump();
        int h;
        clear_mem(0);
        load(0, 0,  enc(OP_ADD, 2, 1, 0, 9));
        load(0, 1,  enc(OP_ADD, 3, 1, 0, 9));
        load(0, 2,  enc(OP_ADD, 0, 1, 0, 77));
        load(0, 3,  enc(OP_JEQ, 0, 2, 3, 7));
        load(0, 4,  enc(OP_HLT, 0, 0, 0, 0));
        load(0, 7,  enc(OP_ST,  0, 7, 1, 50));
        load(0, 8,  enc(OP_JEQ, 0, 2, 0, 20));
        load(0, 9,  enc(OP_ST,  0, 7, 1, 51));
        load(0, 10, enc(OP_ADD, 5, 1, 0, 14));
        load(0, 11, enc(OP_JIN, 0, 5, 0, 0));
        load(0, 12, enc(OP_HLT, 0, 0, 0, 0));
        load(0, 14, enc(OP_ST,  0, 7, 1, 52));
        load(0, 15, enc(OP_ST,  0, 0, 1, 53));
        load(0, 16, enc(OP_HLT, 0, 0, 0, 0));
        exp_q.push_back('{cfg: 0, addr: 16'd50, data: 32'd3});
        exp_q.push_back('{cfg: 0, addr: 16'd51, data: 32'd3});
        exp_q.push_back('{cfg: 0, addr: 16'd52, data: 32'd11});
        exp_q.push_back('{cfg: 0, addr: 16'd53, data: 32'd0});
        run(0, 300, -1, h);
        total += 2;
        if (h !== 72) begin
            bad++;
            $display("FAIL jump_halt_cycle: got %0d want 72", h);
        end
        if (ret_o[0] !== 32'd12) begin
            bad++;
            $display("FAIL jump_retired: got %0d want 12", ret_o[0]);
        end
    endtask

    task automatic test_wrap();
        int h;
        load(2, 0,  enc(OP_JNE, 0, 4, 0, 5));
        load(2, 1,  enc(OP_ADD, 4, 1, 0, 1));
        load(2, 2,  enc(OP_ADD, 2, 1, 0, 15));
        load(2, 3,  enc(OP_JIN, 0, 2, 0, 0));
        load(2, 5,  enc(OP_ST,  0, 3, 1, 10));
        load(2, 6,  enc(OP_ST,  0, 7, 1, 11));
        load(2, 7,  enc(OP_HLT, 0, 0, 0, 0));
        load(2, 15, enc(OP_ADD, 3, 0, 1, 16'hFFFF));
        exp_q.push_back('{cfg: 2, addr: 16'd10, data: 32'hFFFF_FFFF});
        exp_q.push_back('{cfg: 2, addr: 16'd11, data: 32'd0});
        run(2, 200, -1, h);
        total += 2;
        if (h !== 54) begin
            bad++;
            $display("FAIL wrap_halt_cycle: got %0d want 54", h);
        end
        if (ret_o[2] !== 32'd9) begin
            bad++;
            $display("FAIL wrap_retired: got %0d want 9", ret_o[2]);
        end
    endtask

    task automatic test_reset_mid();
        int h;
        clear_mem(0);
        load(0, 0,  enc(OP_ST,  0, 1, 1, 60));
        load(0, 1,  enc(OP_HLT, 0, 0, 0, 0));
        load(0, 60, 32'hDEAD);
        @(negedge clk) start_v[0] = 1'b1;
        @(negedge clk) start_v[0] = 1'b0;
        repeat (5) @(negedge clk);
        total += 2;
        if (we_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL midreset_st_active: got we=%b want 1", we_o[0]);
        end
        reset_v[0] = 1'b1;
        #1;
        if (we_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_we_gated: got %b want 0", we_o[0]);
        end
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        total += 4;
        if (busy_o[0] !== 1'b0 || halted_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: busy=%b halted=%b, want 0 0", busy_o[0], halted_o[0]);
        end
        if (addr_o[0] !== 16'd0) begin
            bad++;
            $display("FAIL midreset_addr: got %0d want 0", addr_o[0]);
        end
        if (ret_o[0] !== 32'd0) begin
            bad++;
            $display("FAIL midreset_retired: got %0d want 0", ret_o[0]);
        end
        if (g_cfg[0].mem[60] !== 32'hDEAD) begin
            bad++;
            $display("FAIL midreset_no_write: mem[60]=%h want 0000dead", g_cfg[0].mem[60]);
        end
        reset_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL midreset_start_ignored: busy=%b want 0", busy_o[0]);
        end
        exp_q.push_back('{cfg: 0, addr: 16'd60, data: 32'd60});
        run(0, 100, -1, h);
        total++;
        if (h !== 12) begin
            bad++;
            $display("FAIL midreset_rerun_cycle: got %0d want 12", h);
        end
    endtask

    initial begin
        reset_v = '1;
        start_v = '0;
        ld_we   = 1'b0;
        ld_cfg  = '0;
        ld_addr = '0;
        ld_data = '0;
        test_reset();
        test_basic();
        test_latency();
        test_ld_st(0, 30);
        test_ld_st(1, 42);
        test_jump();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
